// File: rtl/ex_muldiv_pkg.sv
// Shared encodings and helpers for the iterative M-extension multiply/divide unit.
package ex_muldiv_pkg;

  localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

  localparam logic [2:0] INST_MUL    = 3'b000;
  localparam logic [2:0] INST_MULH   = 3'b001;
  localparam logic [2:0] INST_MULHSU = 3'b010;
  localparam logic [2:0] INST_MULHU  = 3'b011;
  localparam logic [2:0] INST_DIV    = 3'b100;
  localparam logic [2:0] INST_DIVU   = 3'b101;
  localparam logic [2:0] INST_REM    = 3'b110;
  localparam logic [2:0] INST_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic op1_signed(input logic [2:0] f);
    return (f == INST_MUL) || (f == INST_MULH) || (f == INST_MULHSU) ||
           (f == INST_DIV) || (f == INST_REM);
  endfunction

  function automatic logic op2_signed(input logic [2:0] f);
    return (f == INST_MUL) || (f == INST_MULH) || (f == INST_DIV) || (f == INST_REM);
  endfunction

endpackage

// File: rtl/ex_muldiv_iter.sv
// Magnitude datapath: {hi,lo} is the product / {remainder,quotient} pair, advanced
// BITS_PER_CYCLE bits per step. Exposes the post-step value so the final step can be registered.
module muldiv_iter #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            arst,
  input  logic            i_load,
  input  logic            i_step,
  input  logic            i_div,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_hi_nxt,
  output logic [XLEN-1:0] o_lo_nxt
);
  localparam int K = BITS_PER_CYCLE;

  logic [XLEN-1:0]   r_hi, r_lo, r_b;
  logic [XLEN+K-1:0] w_mac;
  logic [XLEN-1:0]   w_mhi, w_mlo, w_dhi, w_dlo;

  // Shift-add: consume K multiplier bits from lo, product bits shift in from the top.
  assign w_mac = {{K{1'b0}}, r_hi} + {{K{1'b0}}, r_b} * {{XLEN{1'b0}}, r_lo[K-1:0]};
  assign w_mhi = w_mac[XLEN+K-1:K];
  assign w_mlo = {w_mac[K-1:0], r_lo[XLEN-1:K]};

  // Restoring divide; remainder stays below the divisor, so bit XLEN of the
  // difference is exactly the borrow.
  always_comb begin
    logic [XLEN:0] w_rem, w_sub;
    w_dhi = r_hi;
    w_dlo = r_lo;
    w_rem = '0;
    w_sub = '0;
    for (int i = 0; i < K; i++) begin
      w_rem = {w_dhi, w_dlo[XLEN-1]};
      w_sub = w_rem - {1'b0, r_b};
      w_dhi = w_sub[XLEN] ? w_rem[XLEN-1:0] : w_sub[XLEN-1:0];
      w_dlo = {w_dlo[XLEN-2:0], ~w_sub[XLEN]};
    end
  end

  assign o_hi_nxt = i_div ? w_dhi : w_mhi;
  assign o_lo_nxt = i_div ? w_dlo : w_mlo;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_hi <= '0;
      r_lo <= '0;
      r_b  <= '0;
    end else if (i_load) begin
      r_hi <= '0;
      r_lo <= i_a;
      r_b  <= i_b;
    end else if (i_step) begin
      r_hi <= o_hi_nxt;
      r_lo <= o_lo_nxt;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M/RV64M unit beside EX: FSM, sign handling, special cases and the
// registered write-back result. Stalls the pipeline through hold_o while iterating.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            arst,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      reg_w_addr_i,
  input  logic            flush_i,
  output logic            hold_o,
  output logic            busy_o,
  output logic            result_valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      reg_w_addr_o,
  output logic            reg_w_ena_o
);
  localparam int N  = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e          r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_funct3;
  logic [4:0]      r_rd;
  logic            r_neg_q, r_neg_r, r_valid;
  logic [XLEN-1:0] r_result;

  logic            w_accept, w_step, w_s1, w_s2, w_div0, w_ovf;
  logic [XLEN-1:0] w_abs1, w_abs2, w_spec_res, w_hi_nxt, w_lo_nxt, w_final;
  logic [2*XLEN-1:0] w_prod;

  assign w_accept = (r_state == S_IDLE) & start_i & ~flush_i;
  assign w_step   = (r_state == S_CALC) & ~flush_i;

  assign w_s1   = op1_signed(funct3_i) & op1_i[XLEN-1];
  assign w_s2   = op2_signed(funct3_i) & op2_i[XLEN-1];
  assign w_abs1 = w_s1 ? -op1_i : op1_i;
  assign w_abs2 = w_s2 ? -op2_i : op2_i;

  assign w_div0 = funct3_i[2] & (op2_i == '0);
  assign w_ovf  = ((funct3_i == INST_DIV) | (funct3_i == INST_REM)) &
                  (op1_i == XMIN) & (op2_i == '1);
  // funct3[1] separates REM/REMU from DIV/DIVU
  assign w_spec_res = w_div0 ? (funct3_i[1] ? op1_i : '1) : (funct3_i[1] ? '0 : XMIN);

  muldiv_iter #(.XLEN(XLEN), .BITS_PER_CYCLE(BITS_PER_CYCLE)) u_iter (
    .clk      (clk),
    .arst     (arst),
    .i_load   (w_accept),
    .i_step   (w_step),
    .i_div    (r_funct3[2]),
    .i_a      (w_abs1),
    .i_b      (w_abs2),
    .o_hi_nxt (w_hi_nxt),
    .o_lo_nxt (w_lo_nxt)
  );

  assign w_prod = r_neg_q ? -{w_hi_nxt, w_lo_nxt} : {w_hi_nxt, w_lo_nxt};

  always_comb begin
    w_final = '0;
    case (r_funct3)
      INST_MUL:                        w_final = w_prod[XLEN-1:0];
      INST_MULH, INST_MULHSU, INST_MULHU: w_final = w_prod[2*XLEN-1:XLEN];
      INST_DIV:                        w_final = r_neg_q ? -w_lo_nxt : w_lo_nxt;
      INST_DIVU:                       w_final = w_lo_nxt;
      INST_REM:                        w_final = r_neg_r ? -w_hi_nxt : w_hi_nxt;
      default:                         w_final = w_hi_nxt;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_funct3 <= '0;
      r_rd     <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_valid  <= 1'b0;
      r_result <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_funct3 <= funct3_i;
          r_rd     <= reg_w_addr_i;
          r_neg_q  <= w_s1 ^ w_s2;
          r_neg_r  <= w_s1;
          r_cnt    <= CW'(N);
          if (w_div0 | w_ovf) begin
            r_result <= w_spec_res;
            r_valid  <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_state  <= S_CALC;
          end
        end
        S_CALC: if (flush_i) begin
          r_state <= S_IDLE;
        end else begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            r_result <= w_final;
            r_valid  <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign hold_o         = w_accept | (r_state == S_CALC);
  assign busy_o         = (r_state != S_IDLE);
  assign result_valid_o = r_valid;
  assign reg_w_ena_o    = r_valid;
  assign result_o       = r_result;
  assign reg_w_addr_o   = r_rd;

endmodule
